// File: rtl/note_plotter.sv
// Note plotter: turns valve keys plus airflow level into a note id, waits
// until that id has been stable for HOLD_CYCLES, then erases the previous
// 4x4 note-head box and draws the new one through the VGA adapter's pixel
// write port, one pixel per cycle.
module note_plotter #(
  parameter logic [7:0] X_POS       = 8'd80,
  parameter logic [6:0] Y_BASE      = 7'd90,
  parameter int         STEP        = 3,
  parameter int         HOLD_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [2:0] keys,
  input  logic [1:0] airflow,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic [3:0] note_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2
  } state_t;

  localparam logic [19:0] HOLD         = 20'(HOLD_CYCLES);
  localparam logic [6:0]  STEP7        = 7'(STEP);
  localparam logic [2:0]  COL_SHARP    = 3'b100;
  localparam logic [2:0]  COL_NATURAL  = 3'b001;
  localparam logic [2:0]  COL_ERASE    = 3'b111;

  // Staff position (0 = C4 line) for each note id.
  function automatic logic [2:0] pos_of(input logic [3:0] id);
    case (id)
      4'd1, 4'd2:   pos_of = 3'd0;
      4'd3, 4'd4:   pos_of = 3'd1;
      4'd5:         pos_of = 3'd2;
      4'd6, 4'd7:   pos_of = 3'd3;
      4'd8, 4'd9:   pos_of = 3'd4;
      4'd10, 4'd11: pos_of = 3'd5;
      4'd12:        pos_of = 3'd6;
      4'd13:        pos_of = 3'd7;
      default:      pos_of = 3'd0;
    endcase
  endfunction

  // Sharps share a staff position with their natural and differ by colour.
  function automatic logic is_sharp(input logic [3:0] id);
    case (id)
      4'd2, 4'd4, 4'd7, 4'd9, 4'd11: is_sharp = 1'b1;
      default:                       is_sharp = 1'b0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cand;
  logic [3:0]  cand_q, cand_d;
  logic [19:0] cnt_q, cnt_d;
  logic        stable;
  logic [3:0]  note_id_q, note_id_d;
  logic [3:0]  target_q, target_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  colour_q, colour_d;
  logic        plot_q, plot_d;
  logic [3:0]  box_id;
  logic [2:0]  box_pos;
  logic [6:0]  y_top;
  logic [7:0]  pix_x;
  logic [6:0]  pix_y;

  // Decode keys and airflow into the candidate note id (0 = no note).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cand = 4'd0;
    case (airflow)
      2'b01: begin
        case (keys)
          3'b000:  cand = 4'd1;
          3'b111:  cand = 4'd2;
          3'b101:  cand = 4'd3;
          3'b011:  cand = 4'd4;
          3'b110:  cand = 4'd5;
          3'b100:  cand = 4'd6;
          3'b010:  cand = 4'd7;
          default: cand = 4'd0;
        endcase
      end
      2'b10: begin
        case (keys)
          3'b000:  cand = 4'd8;
          3'b011:  cand = 4'd9;
          3'b110:  cand = 4'd10;
          3'b100:  cand = 4'd11;
          3'b010:  cand = 4'd12;
          3'b001:  cand = 4'd13;
          default: cand = 4'd0;
        endcase
      end
      default: cand = 4'd0;
    endcase
  end

  // Stability filter: count cycles the candidate has held, saturating at HOLD.
  always_comb begin
    cand_d = cand;
    if (cand != cand_q) begin
      cnt_d = 20'd0;
    end else if (cnt_q == HOLD) begin
      cnt_d = HOLD;
    end else begin
      cnt_d = cnt_q + 20'd1;
    end
  end

  assign stable = (cnt_q == HOLD);

  // Box geometry: erase uses the note on screen, draw uses the latched target.
  always_comb begin
    box_id  = (state_q == ERASE) ? note_id_q : target_q;
    box_pos = pos_of(box_id);
    y_top   = Y_BASE - ({4'd0, box_pos} * STEP7);
    pix_x   = X_POS + {6'd0, idx_q[1:0]};
    pix_y   = y_top + {5'd0, idx_q[3:2]};
  end

  // Next-state and registered pixel-port values for the IDLE/ERASE/DRAW FSM.
  always_comb begin
    state_d   = state_q;
    note_id_d = note_id_q;
    target_d  = target_q;
    idx_d     = idx_q;
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    plot_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (stable && (cand_q != note_id_q)) begin
          target_d = cand_q;
          idx_d    = 4'd0;
          state_d  = (note_id_q != 4'd0) ? ERASE : DRAW;
        end
      end
      ERASE: begin
        plot_d   = 1'b1;
        x_d      = pix_x;
        y_d      = pix_y;
        colour_d = COL_ERASE;
        idx_d    = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          note_id_d = 4'd0;
          state_d   = (target_q != 4'd0) ? DRAW : IDLE;
        end
      end
      DRAW: begin
        plot_d   = 1'b1;
        x_d      = pix_x;
        y_d      = pix_y;
        colour_d = is_sharp(target_q) ? COL_SHARP : COL_NATURAL;
        idx_d    = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          note_id_d = target_q;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, filter and pixel-port registers; reset abandons any pass in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cand_q    <= 4'd0;
      cnt_q     <= 20'd0;
      note_id_q <= 4'd0;
      target_q  <= 4'd0;
      idx_q     <= 4'd0;
      x_q       <= 8'd0;
      y_q       <= 7'd0;
      colour_q  <= 3'd0;
      plot_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      note_id_q <= note_id_d;
      target_q  <= target_d;
      idx_q     <= idx_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
    end
  end

  assign x       = x_q;
  assign y       = y_q;
  assign colour  = colour_q;
  assign plot    = plot_q;
  assign busy    = (state_q != IDLE);
  assign note_id = note_id_q;

endmodule

// File: tb/tb_note_plotter.sv
// Directed bench for note_plotter with a short hold time (4 cycles).
module tb_note_plotter;

  logic       clock = 1'b0;
  logic       resetn;
  logic [2:0] keys;
  logic [1:0] airflow;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic [3:0] note_id;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] px [64];
  logic [6:0] py [64];
  logic [2:0] pc [64];

  note_plotter #(.HOLD_CYCLES(4)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .keys    (keys),
    .airflow (airflow),
    .x       (x),
    .y       (y),
    .colour  (colour),
    .plot    (plot),
    .busy    (busy),
    .note_id (note_id)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Wait (bounded) on falling edges until plot is seen high.
  task automatic wait_plot(input int limit, output int waited);
    waited = 0;
    while (plot !== 1'b1 && waited < limit) begin
      @(negedge clock);
      waited++;
    end
  endtask

  // Record consecutive plotted pixels; optionally change keys at sample change_at.
  task automatic grab(input int change_at, input logic [2:0] new_keys, output int n);
    n = 0;
    while (plot === 1'b1 && n < 64) begin
      px[n] = x;
      py[n] = y;
      pc[n] = colour;
      if (n == change_at) keys = new_keys;
      n++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    resetn  = 1'b0;
    airflow = 2'b00;
    keys    = 3'b000;
    repeat (2) @(negedge clock);
    n_checks++; if (plot !== 1'b0)    begin n_fail++; $display("FAIL reset_plot: got %b expected 0", plot); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (note_id !== 4'd0) begin n_fail++; $display("FAIL reset_note_id: got %0d expected 0", note_id); end
    n_checks++; if (x !== 8'd0)       begin n_fail++; $display("FAIL reset_x: got %0d expected 0", x); end
    n_checks++; if (y !== 7'd0)       begin n_fail++; $display("FAIL reset_y: got %0d expected 0", y); end
    n_checks++; if (colour !== 3'd0)  begin n_fail++; $display("FAIL reset_colour: got %0d expected 0", colour); end
  endtask

  task automatic test_first_draw;
    int w, n;
    airflow = 2'b01;
    keys    = 3'b000;
    @(negedge clock);
    resetn = 1'b1;
    wait_plot(50, w);
    n_checks++; if (plot !== 1'b1) begin n_fail++; $display("FAIL first_timeout: plot got %b expected 1", plot); end
    n_checks++; if (w != 7) begin n_fail++; $display("FAIL first_latency: got %0d expected 7", w); end
    grab(-1, 3'b000, n);
    n_checks++; if (n != 16) begin n_fail++; $display("FAIL first_count: got %0d expected 16", n); end
    for (int i = 0; i < 16 && i < n; i++) begin
      n_checks++;
      if ({px[i], py[i], pc[i]} !== {8'(80 + i % 4), 7'(90 + i / 4), 3'b001}) begin
        n_fail++;
        $display("FAIL first_pix%0d: got x%0d y%0d c%0d expected x%0d y%0d c1",
                 i, px[i], py[i], pc[i], 80 + i % 4, 90 + i / 4);
      end
    end
    n_checks++; if (note_id !== 4'd1) begin n_fail++; $display("FAIL first_note_id: got %0d expected 1", note_id); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL first_busy: got %b expected 0", busy); end
  endtask

  task automatic test_replace;
    int w, n;
    airflow = 2'b10;
    keys    = 3'b011;
    wait_plot(50, w);
    n_checks++; if (plot !== 1'b1) begin n_fail++; $display("FAIL replace_timeout: plot got %b expected 1", plot); end
    n_checks++; if (w != 7) begin n_fail++; $display("FAIL replace_latency: got %0d expected 7", w); end
    grab(-1, 3'b000, n);
    n_checks++; if (n != 32) begin n_fail++; $display("FAIL replace_count: got %0d expected 32", n); end
    for (int i = 0; i < 32 && i < n; i++) begin
      int ey, ec;
      ey = (i < 16) ? 90 + (i % 16) / 4 : 78 + (i % 16) / 4;
      ec = (i < 16) ? 7 : 4;
      n_checks++;
      if ({px[i], py[i], pc[i]} !== {8'(80 + i % 4), 7'(ey), 3'(ec)}) begin
        n_fail++;
        $display("FAIL replace_pix%0d: got x%0d y%0d c%0d expected x%0d y%0d c%0d",
                 i, px[i], py[i], pc[i], 80 + i % 4, ey, ec);
      end
    end
    n_checks++; if (note_id !== 4'd9) begin n_fail++; $display("FAIL replace_note_id: got %0d expected 9", note_id); end
  endtask

  task automatic test_erase_only;
    int w, n, extra;
    airflow = 2'b00;
    wait_plot(50, w);
    n_checks++; if (plot !== 1'b1) begin n_fail++; $display("FAIL erase_timeout: plot got %b expected 1", plot); end
    grab(-1, 3'b000, n);
    n_checks++; if (n != 16) begin n_fail++; $display("FAIL erase_count: got %0d expected 16", n); end
    for (int i = 0; i < 16 && i < n; i++) begin
      n_checks++;
      if ({px[i], py[i], pc[i]} !== {8'(80 + i % 4), 7'(78 + i / 4), 3'b111}) begin
        n_fail++;
        $display("FAIL erase_pix%0d: got x%0d y%0d c%0d expected x%0d y%0d c7",
                 i, px[i], py[i], pc[i], 80 + i % 4, 78 + i / 4);
      end
    end
    n_checks++; if (note_id !== 4'd0) begin n_fail++; $display("FAIL erase_note_id: got %0d expected 0", note_id); end
    extra = 0;
    repeat (20) begin
      @(negedge clock);
      if (plot === 1'b1) extra++;
    end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL erase_no_draw: got %0d plot cycles expected 0", extra); end
  endtask

  task automatic test_toggle;
    int plots;
    plots   = 0;
    airflow = 2'b01;
    for (int c = 0; c < 100; c++) begin
      if (c % 3 == 0) keys = ((c / 3) % 2 != 0) ? 3'b101 : 3'b000;
      @(negedge clock);
      if (plot === 1'b1) plots++;
    end
    n_checks++; if (plots != 0) begin n_fail++; $display("FAIL toggle_plots: got %0d expected 0", plots); end
    n_checks++; if (note_id !== 4'd0) begin n_fail++; $display("FAIL toggle_note_id: got %0d expected 0", note_id); end
  endtask

  task automatic test_mid_draw_change;
    int w, n;
    airflow = 2'b01;
    keys    = 3'b101;
    wait_plot(50, w);
    n_checks++; if (plot !== 1'b1) begin n_fail++; $display("FAIL middraw_timeout: plot got %b expected 1", plot); end
    grab(5, 3'b110, n);
    n_checks++; if (n != 16) begin n_fail++; $display("FAIL middraw_count: got %0d expected 16", n); end
    for (int i = 0; i < 16 && i < n; i++) begin
      n_checks++;
      if ({px[i], py[i], pc[i]} !== {8'(80 + i % 4), 7'(87 + i / 4), 3'b001}) begin
        n_fail++;
        $display("FAIL middraw_pix%0d: got x%0d y%0d c%0d expected x%0d y%0d c1",
                 i, px[i], py[i], pc[i], 80 + i % 4, 87 + i / 4);
      end
    end
    n_checks++; if (note_id !== 4'd3) begin n_fail++; $display("FAIL middraw_note_id: got %0d expected 3", note_id); end
    wait_plot(50, w);
    n_checks++; if (plot !== 1'b1) begin n_fail++; $display("FAIL followup_timeout: plot got %b expected 1", plot); end
    grab(-1, 3'b000, n);
    n_checks++; if (n != 32) begin n_fail++; $display("FAIL followup_count: got %0d expected 32", n); end
    for (int i = 0; i < 32 && i < n; i++) begin
      int ey, ec;
      ey = (i < 16) ? 87 + (i % 16) / 4 : 84 + (i % 16) / 4;
      ec = (i < 16) ? 7 : 1;
      n_checks++;
      if ({px[i], py[i], pc[i]} !== {8'(80 + i % 4), 7'(ey), 3'(ec)}) begin
        n_fail++;
        $display("FAIL followup_pix%0d: got x%0d y%0d c%0d expected x%0d y%0d c%0d",
                 i, px[i], py[i], pc[i], 80 + i % 4, ey, ec);
      end
    end
    n_checks++; if (note_id !== 4'd5) begin n_fail++; $display("FAIL followup_note_id: got %0d expected 5", note_id); end
  endtask

  task automatic test_reset_mid_draw;
    int w, n;
    airflow = 2'b10;
    keys    = 3'b010;
    wait_plot(50, w);
    n_checks++; if (plot !== 1'b1) begin n_fail++; $display("FAIL rstmid_timeout: plot got %b expected 1", plot); end
    repeat (23) @(negedge clock);
    n_checks++;
    if ({plot, x, y, colour} !== {1'b1, 8'd83, 7'd73, 3'b001}) begin
      n_fail++;
      $display("FAIL rstmid_pix7: got p%b x%0d y%0d c%0d expected p1 x83 y73 c1", plot, x, y, colour);
    end
    resetn = 1'b0;
    #1;
    n_checks++; if (plot !== 1'b0)    begin n_fail++; $display("FAIL rstmid_plot: got %b expected 0", plot); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_checks++; if (note_id !== 4'd0) begin n_fail++; $display("FAIL rstmid_note_id: got %0d expected 0", note_id); end
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    wait_plot(50, w);
    n_checks++; if (plot !== 1'b1) begin n_fail++; $display("FAIL redraw_timeout: plot got %b expected 1", plot); end
    n_checks++; if (w != 7) begin n_fail++; $display("FAIL redraw_latency: got %0d expected 7", w); end
    grab(-1, 3'b000, n);
    n_checks++; if (n != 16) begin n_fail++; $display("FAIL redraw_count: got %0d expected 16", n); end
    for (int i = 0; i < 16 && i < n; i++) begin
      n_checks++;
      if ({px[i], py[i], pc[i]} !== {8'(80 + i % 4), 7'(72 + i / 4), 3'b001}) begin
        n_fail++;
        $display("FAIL redraw_pix%0d: got x%0d y%0d c%0d expected x%0d y%0d c1",
                 i, px[i], py[i], pc[i], 80 + i % 4, 72 + i / 4);
      end
    end
    n_checks++; if (note_id !== 4'd12) begin n_fail++; $display("FAIL redraw_note_id: got %0d expected 12", note_id); end
  endtask

  initial begin
    test_reset;
    test_first_draw;
    test_replace;
    test_erase_only;
    test_toggle;
    test_mid_draw_change;
    test_reset_mid_draw;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
